// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Owns the PC, issues sequential word fetches to instruction memory, and buffers
// in-order responses as {pc, data} pairs for decode. A redirect flushes the buffer,
// marks every in-flight response as stale and restarts fetching at the new PC.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] stale;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   entry_t        fifo_mem [FIFO_DEPTH];

   logic          credit_ok;
   logic          req_fire;
   logic          deq;
   logic          resp_keep;
   logic [CW:0]   inflight;
   logic [CW-1:0] outstanding_nxt;
   logic [31:0]   redirect_aligned;
   logic          unused_redirect_lsbs;

   // Low address bits of a redirect are meaningless for word fetches.
   assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Buffered entries plus in-flight requests may never exceed the buffer size,
   // so every kept response is guaranteed a slot.
   assign inflight  = {1'b0, count} + {1'b0, outstanding};
   assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);

   assign imem_req_valid = !rst && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid = !rst && (count != '0);
   assign inst_pc    = fifo_mem[rd_ptr].pc;
   assign inst_data  = fifo_mem[rd_ptr].data;
   assign deq        = inst_valid && inst_ready;

   // A response in a redirect cycle belongs to the old stream and is dropped.
   assign resp_keep       = imem_resp_valid && (stale == '0) && !redirect_valid;
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

   // PC tracking, in-flight request count and stale-response bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         stale       <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            stale    <= outstanding_nxt;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (resp_keep)
               resp_pc <= resp_pc + 32'd4;
            if (imem_resp_valid && (stale != '0))
               stale <= stale - CW'(1);
         end
      end
   end

   // Buffer pointers and occupancy; a redirect empties the buffer after any dequeue.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (resp_keep)
            wr_ptr <= wr_ptr + PW'(1);
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(resp_keep) - CW'(deq);
      end
   end

   // Buffer storage; reset gives a defined head of {RESET_PC, 0}.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i].pc   <= RESET_PC;
            fifo_mem[i].data <= '0;
         end
      end else if (resp_keep) begin
         fifo_mem[wr_ptr].pc   <= resp_pc;
         fifo_mem[wr_ptr].data <= imem_resp_data;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      resp_keep |-> (count < CW'(FIFO_DEPTH)));
   a_resp_expected: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus pushes the expected {pc} stream,
// a behavioural memory answers requests in order after mem_lat cycles, and a
// monitor pops and compares every instruction decode consumes.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data  = '0;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int mem_lat = 1;
   int fire_cnt = 0;
   int deq_cnt  = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] exp_q[$];

   ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] p;
      p = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(p);
         p = p + 32'd4;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory: note accepted requests (sampled mid-cycle) with their due cycle.
   always @(negedge clk) begin
      pend_t p;
      if (rst) pend_q.delete();
      else if (imem_req_valid && imem_req_ready) begin
         p.addr = imem_req_addr;
         p.due  = cyc + mem_lat;
         pend_q.push_back(p);
      end
   end

   // Memory: present at most one in-order response per cycle.
   always begin
      @(posedge clk);
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_fn(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   end

   // Monitor: count fires, and check each consumed instruction against the scoreboard.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) begin
         fire_cnt = 0;
         deq_cnt  = 0;
      end else begin
         if (imem_req_valid && imem_req_ready) fire_cnt++;
         if (inst_valid && inst_ready) begin
            deq_cnt++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL deq_unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
               e = exp_q.pop_front();
               chk("inst_pc", inst_pc, e);
               chk("inst_data", inst_data, mem_fn(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int v;
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; mem_lat = 1;

      // Reset values
      repeat (2) tick();
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst_pc", inst_pc, RST_PC);
      chk("rst_inst_data", inst_data, 32'd0);

      // Sequential fetch, single-cycle memory, decode always ready
      tick(); rst = 1'b0; inst_ready = 1'b1; exp_q.delete(); push_seq(RST_PC, 64);
      @(negedge clk);
      chk("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t1_first_req_addr", imem_req_addr, RST_PC);
      tick(); @(negedge clk);
      chk("t1_lat_c1", {31'b0, inst_valid}, 32'd0);
      tick(); @(negedge clk);
      chk("t1_lat_c2", {31'b0, inst_valid}, 32'd1);
      v = 0;
      repeat (8) begin tick(); @(negedge clk); if (inst_valid) v++; end
      chk("t1_throughput", v, 32'd8);

      // Decode stalled: credit caps issue at 4, then resume at +0x10
      tick(); rst = 1'b1; inst_ready = 1'b0;
      tick(); rst = 1'b0; exp_q.delete(); push_seq(RST_PC, 64);
      repeat (10) tick();
      @(negedge clk);
      chk("t2_fires", fire_cnt, 32'd4);
      chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_next_addr", imem_req_addr, 32'h8000_0010);
      chk("t2_head_pc", inst_pc, RST_PC);
      tick(); inst_ready = 1'b1;
      tick(); @(negedge clk);
      chk("t2_resume_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t2_resume_addr", imem_req_addr, 32'h8000_0010);
      repeat (12) tick();
      @(negedge clk);
      chk("t2_drain", {31'b0, deq_cnt >= 12}, 32'd1);

      // Latency 3, two in flight, redirect to unaligned target
      tick(); rst = 1'b1; inst_ready = 1'b0; imem_req_ready = 1'b0;
      tick(); rst = 1'b0; mem_lat = 3; exp_q.delete();
      tick(); imem_req_ready = 1'b1;
      tick();
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
      @(negedge clk);
      chk("t3_redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("t3_two_in_flight", fire_cnt, 32'd2);
      tick(); redirect_valid = 1'b0; inst_ready = 1'b1; exp_q.delete(); push_seq(32'h8000_1000, 32);
      @(negedge clk);
      chk("t3_restart_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t3_restart_addr", imem_req_addr, 32'h8000_1000);
      chk("t3_fifo_empty", {31'b0, inst_valid}, 32'd0);
      repeat (20) tick();
      @(negedge clk);
      chk("t3_delivered", {31'b0, deq_cnt >= 5}, 32'd1);

      // Redirect with concurrent dequeue and arriving response
      tick(); rst = 1'b1; inst_ready = 1'b0;
      tick(); rst = 1'b0; mem_lat = 1; inst_ready = 1'b1; exp_q.delete(); push_seq(RST_PC, 32);
      repeat (6) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      @(negedge clk);
      chk("t4_head_valid", {31'b0, inst_valid}, 32'd1);
      tick(); redirect_valid = 1'b0; exp_q.delete(); push_seq(32'h0000_0100, 32);
      @(negedge clk);
      chk("t4_flushed", {31'b0, inst_valid}, 32'd0);
      chk("t4_restart_addr", imem_req_addr, 32'h0000_0100);
      repeat (5) tick();
      // Back-to-back redirects: the later target wins
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
      tick(); redirect_pc = 32'h0000_3000;
      tick(); redirect_valid = 1'b0; exp_q.delete(); push_seq(32'h0000_3000, 32);
      @(negedge clk);
      chk("t4_b2b_addr", imem_req_addr, 32'h0000_3000);
      chk("t4_b2b_empty", {31'b0, inst_valid}, 32'd0);
      repeat (6) tick();

      // Address wrap at the top of memory
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick(); redirect_valid = 1'b0; exp_q.delete(); push_seq(32'hFFFF_FFFC, 16);
      @(negedge clk);
      chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick(); @(negedge clk);
      chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
      repeat (8) tick();

      // Reset mid-stream with three buffered entries
      inst_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
      tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; exp_q.delete();
      tick();
      tick();
      tick(); imem_req_ready = 1'b0;
      tick();
      tick(); @(negedge clk);
      chk("t6_buffered_head", inst_pc, 32'h0000_4000);
      chk("t6_credit_left", {31'b0, imem_req_valid}, 32'd1);
      tick(); rst = 1'b1; imem_req_ready = 1'b1;
      @(negedge clk);
      chk("t6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      tick(); rst = 1'b0; inst_ready = 1'b1; exp_q.delete(); push_seq(RST_PC, 16);
      @(negedge clk);
      chk("t6_post_rst_req", {31'b0, imem_req_valid}, 32'd1);
      chk("t6_post_rst_addr", imem_req_addr, RST_PC);
      chk("t6_post_rst_empty", {31'b0, inst_valid}, 32'd0);
      repeat (8) tick();
      @(negedge clk);
      chk("t6_delivered", {31'b0, deq_cnt >= 5}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the requesting side of the instruction-memory interface. It owns the PC, issues sequential word fetches to the instruction memory over a valid/ready request channel, and collects in-order responses into a small instruction buffer. It presents (pc, instruction) pairs to decode through a valid/ready handshake. A redirect from execute/branch flushes the buffer, discards in-flight responses, and restarts fetching at the new PC.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; also the cap on in-flight requests plus buffered entries (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  32  fetch address, always word-aligned
- imem_resp_valid  in  1  response data valid; responses return in request order, ≥1 cycle after acceptance, with no backpressure
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode consumes the head
- inst_data  out  32  instruction at head
- inst_pc  out  32  PC of the head instruction
- redirect_valid  in  1  flush and restart
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)

## Operation
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC tagged onto the next kept response.
  - outstanding: accepted requests not yet answered, width clog2(FIFO_DEPTH+1).
  - stale: how many of the outstanding responses must be dropped.
  - FIFO of {pc, data} with count.
- Request rule: imem_req_valid = !rst && !redirect_valid && (count + outstanding < FIFO_DEPTH). imem_req_addr = fetch_pc.
- Request fire (valid && ready): fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response, stale > 0: discard the data, stale -= 1, outstanding -= 1.
- Response, stale = 0: enqueue {resp_pc, data}, resp_pc += 4, outstanding -= 1. The credit rule guarantees the FIFO is never full when a kept response arrives. Overflow is an assertion failure.
- Dequeue: inst_valid && inst_ready pops the head.
- Redirect cycle:
  - No request is issued.
  - A dequeue in the same cycle is honoured (decode saw it).
  - The FIFO is then emptied.
  - fetch_pc and resp_pc are set to {redirect_pc[31:2], 2'b00}.
  - stale_next = outstanding_next (outstanding after this cycle's response decrement). Any response arriving in the redirect cycle is discarded and is not counted.
- Back-to-back redirects: the later one wins and all in-flight responses remain stale.
- Simultaneous request fire, response and dequeue in one cycle: all three take effect, and count and outstanding are updated net.

## Timing
- Reset values:
  - imem_req_valid=0 during the rst cycle.
  - imem_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=RESET_PC.
  - outstanding=0, stale=0, count=0.
- First request: imem_req_valid=1 in the first cycle after rst deasserts, with address RESET_PC.
- Latency: request accepted at T, response at T+k (k≥1), inst_valid=1 at T+k+1. There is no combinational bypass from imem_resp to inst_*.
- Throughput: one instruction per cycle sustained when memory is single-cycle and inst_ready=1.
- Restart: the first request at the redirect target is issued the cycle after redirect_valid, provided credit is available.
- rst mid-operation: all state returns to reset values. Responses to requests issued before reset are the memory's responsibility (the memory is reset on the same rst).

## Test plan
- Reset fetch, single-cycle memory, inst_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008…. inst_valid is first seen 2 cycles after the first request, then inst_pc advances by 4 every cycle.
- Hold inst_ready=0, memory always ready → exactly 4 requests issued, then imem_req_valid=0. Release inst_ready → fetching resumes at 0x80000010 with no lost or duplicated PCs.
- Memory latency 3, two requests outstanding, redirect to 0x80001002 → both late responses dropped, FIFO empty. The next request address is 0x80001000, and the first inst_pc delivered is 0x80001000.
- Redirect in the same cycle as inst_ready=1 on a valid head and an arriving response → head counted consumed, response discarded, inst_valid=0 next cycle.
- fetch_pc=0xFFFFFFFC → next request address is 0x00000000.
- Assert rst for one cycle mid-stream with 3 buffered entries → inst_valid=0 and imem_req_valid=0 that cycle. The next request is at RESET_PC.
